// File: rtl/if_id_stage_pkg.sv
// Shared CPU package: fetch-stage constants, FSM state type
// and the IF/ID pipeline bundle.
package if_id_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_NPC = 32'h0000_0004;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'h0000_0004;
    localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;

    // Delay-slot tracker state. Kept as a plain vector so the
    // encodings stay visible to older tools and waveform viewers.
    typedef logic [0:0] fsm_state_t;

    localparam fsm_state_t ST_SEQ  = 1'b0;
    localparam fsm_state_t ST_SLOT = 1'b1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  npc;
        logic               valid;
        logic               dslot;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = '{
        instr: NOP_WORD,
        pc:    32'h0000_0000,
        npc:   32'h0000_0000,
        valid: 1'b0,
        dslot: 1'b0
    };

    // Sequential successor address; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] next_seq_addr(
        input logic [ADDR_W-1:0] addr
    );
        return addr + PC_STEP;
    endfunction

endpackage

// File: rtl/if_id_stage_pc_npc_unit.sv
// PC/nPC pair with delayed-branch update: the instruction at
// nPC always executes before a redirect reaches the PC.
module pc_npc_unit
    import if_id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              le,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] target_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] npc_q;
    logic [ADDR_W-1:0] npc_d;

    // Next PC/nPC: hold on stall, else shift nPC into PC and
    // load nPC from the redirect target or the next word.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (le) begin
            pc_d = npc_q;
            if (branch_taken) begin
                npc_d = target_addr;
            end else begin
                npc_d = next_seq_addr(npc_q);
            end
        end
    end

    // PC/nPC registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_NPC;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc  = pc_q;
    assign npc = npc_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register with delay-slot
// tracking; the instruction ROM is read combinationally at PC.
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               LE,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  target_addr,
    input  logic               annul,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] instr_ID,
    output logic [ADDR_W-1:0]  pc_ID,
    output logic [ADDR_W-1:0]  npc_ID,
    output logic               valid_ID,
    output logic               dslot_ID
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;

    fsm_state_t state_q;
    fsm_state_t state_d;

    if_id_t ifid_q;
    if_id_t ifid_d;

    pc_npc_unit u_pc_npc (
        .clk          (clk),
        .reset        (reset),
        .le           (LE),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .pc           (pc),
        .npc          (npc)
    );

    // Fetch address is the live PC, no extra pipeline delay.
    assign imem_addr = pc;

    // Delay-slot tracker: a taken redirect makes the next fetch
    // a slot; a redirect from inside a slot starts a fresh slot.
    always_comb begin
        state_d = state_q;
        if (LE) begin
            if (branch_taken) begin
                state_d = ST_SLOT;
            end else begin
                state_d = ST_SEQ;
            end
        end
    end

    // IF/ID capture: annul squashes the word but keeps its PC
    // pair so later stages still see where the slot lived.
    always_comb begin
        ifid_d = ifid_q;
        if (LE) begin
            ifid_d.pc    = pc;
            ifid_d.npc   = npc;
            ifid_d.dslot = (state_q == ST_SLOT);
            if (annul) begin
                ifid_d.instr = NOP_WORD;
                ifid_d.valid = 1'b0;
            end else begin
                ifid_d.instr = imem_data;
                ifid_d.valid = 1'b1;
            end
        end
    end

    // State and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SEQ;
            ifid_q  <= IF_ID_RESET;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
        end
    end

    assign instr_ID = ifid_q.instr;
    assign pc_ID    = ifid_q.pc;
    assign npc_ID   = ifid_q.npc;
    assign valid_ID = ifid_q.valid;
    assign dslot_ID = ifid_q.dslot;

endmodule
